// File: rtl/sprite_scheduler_if.sv
// rtl/sprite_scheduler_if.sv - attribute write, scanline and pixel-select signal bundle
// master drives writes/line/pixel requests; slave is the scheduler.
interface sprite_scheduler_if;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [10:0] wr_x;
  logic [9:0]  wr_y;
  logic [3:0]  wr_index;
  logic        wr_enable;
  logic        line_start;
  logic [10:0] line_y;
  logic [10:0] pix_x;
  logic        busy;
  logic        sprite_hit;
  logic [10:0] sprite_x;
  logic [9:0]  sprite_y;
  logic [3:0]  sprite_index;
  logic        overflow;

  modport master (
    output wr_en, wr_sel, wr_x, wr_y, wr_index, wr_enable, line_start, line_y, pix_x,
    input  busy, sprite_hit, sprite_x, sprite_y, sprite_index, overflow
  );

  modport slave (
    input  wr_en, wr_sel, wr_x, wr_y, wr_index, wr_enable, line_start, line_y, pix_x,
    output busy, sprite_hit, sprite_x, sprite_y, sprite_index, overflow
  );
endinterface

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - per-scanline sprite list builder and pixel sprite selector
// Overflow flag is built only when SPRITE_SCHED_OVERFLOW_EN is defined.
module sprite_scheduler #(
  parameter int NUM_SPRITES  = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_SIZE  = 32
) (
  input  logic              clk,
  input  logic              reset,
  sprite_scheduler_if.slave bus
);
  localparam int               PTR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_SPRITES - 1);
  localparam logic [11:0]      SIZE  = 12'(SPRITE_SIZE);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_n;

  logic [10:0]            tbl_x   [NUM_SPRITES];
  logic [9:0]             tbl_y   [NUM_SPRITES];
  logic [3:0]             tbl_idx [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] tbl_en;

  logic [PTR_W-1:0]        ptr;
  logic [10:0]             line_q;
  logic [11:0]             line12, y12, pix12;
  logic                    scan_vis;
  logic [MAX_PER_LINE-1:0] pend_v, act_v, slot_wr;
  logic [10:0]             pend_x   [MAX_PER_LINE];
  logic [9:0]              pend_y   [MAX_PER_LINE];
  logic [3:0]              pend_idx [MAX_PER_LINE];
  logic [10:0]             act_x    [MAX_PER_LINE];
  logic [9:0]              act_y    [MAX_PER_LINE];
  logic [3:0]              act_idx  [MAX_PER_LINE];

  logic        hit_n, hit_q;
  logic [10:0] x_n, x_q;
  logic [9:0]  y_n, y_q;
  logic [3:0]  idx_n, idx_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // line_start restarts the scan from any state, including mid-scan and COMMIT
  always_comb begin
    state_n = state;
    if (bus.line_start) begin
      state_n = SCAN;
    end else begin
      case (state)
        SCAN:    if (ptr == LAST) state_n = COMMIT;
        COMMIT:  state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_en <= '0;
    end else if (bus.wr_en) begin
      tbl_x[bus.wr_sel]   <= bus.wr_x;
      tbl_y[bus.wr_sel]   <= bus.wr_y;
      tbl_idx[bus.wr_sel] <= bus.wr_index;
      tbl_en[bus.wr_sel]  <= bus.wr_enable;
    end
  end

  assign line12   = {1'b0, line_q};
  assign y12      = {2'b00, tbl_y[ptr]};
  assign scan_vis = (state == SCAN) && !bus.line_start && tbl_en[ptr] &&
                    (line12 >= y12) && (line12 < y12 + SIZE);

  // pend_v fills contiguously from slot 0, so the first clear slot is the append point
  always_comb begin
    logic prev;
    slot_wr = '0;
    prev    = 1'b1;
    for (int i = 0; i < MAX_PER_LINE; i++) begin
      slot_wr[i] = scan_vis && !pend_v[i] && prev;
      prev       = pend_v[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      line_q <= '0;
      pend_v <= '0;
      act_v  <= '0;
    end else if (bus.line_start) begin
      ptr    <= '0;
      line_q <= bus.line_y;
      pend_v <= '0;
    end else if (state == SCAN) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        if (slot_wr[i]) begin
          pend_v[i]   <= 1'b1;
          pend_x[i]   <= tbl_x[ptr];
          pend_y[i]   <= tbl_y[ptr];
          pend_idx[i] <= tbl_idx[ptr];
        end
      end
    end else if (state == COMMIT) begin
      act_v <= pend_v;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        act_x[i]   <= pend_x[i];
        act_y[i]   <= pend_y[i];
        act_idx[i] <= pend_idx[i];
      end
    end
  end

`ifdef SPRITE_SCHED_OVERFLOW_EN
  logic dropped, overflow_q;

  // a visible entry arriving with the list full means more than MAX_PER_LINE were visible
  always_ff @(posedge clk) begin
    if (reset) begin
      dropped    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.line_start) begin
      dropped <= 1'b0;
    end else if (scan_vis && pend_v[MAX_PER_LINE-1]) begin
      dropped <= 1'b1;
    end else if (state == COMMIT) begin
      overflow_q <= dropped;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign pix12 = {1'b0, bus.pix_x};

  // walk from the highest slot down so the lowest hitting slot is the last to assign
  always_comb begin
    hit_n = 1'b0;
    x_n   = '0;
    y_n   = '0;
    idx_n = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      if (act_v[i] && (pix12 >= {1'b0, act_x[i]}) && (pix12 < {1'b0, act_x[i]} + SIZE)) begin
        hit_n = 1'b1;
        x_n   = act_x[i];
        y_n   = act_y[i];
        idx_n = act_idx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
    end else begin
      hit_q <= hit_n;
      x_q   <= x_n;
      y_q   <= y_n;
      idx_q <= idx_n;
    end
  end

  assign bus.sprite_hit   = hit_q;
  assign bus.sprite_x     = x_q;
  assign bus.sprite_y     = y_q;
  assign bus.sprite_index = idx_q;
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - self-checking bench for sprite_scheduler
// Queue-based reference model, per-cycle compare, directed literal checks, random traffic.
module tb_sprite_scheduler;
  localparam int N    = 8;
  localparam int MAXL = 4;
  localparam int SZ   = 32;
`ifdef SPRITE_SCHED_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sprite_scheduler_if bus();

  sprite_scheduler #(.NUM_SPRITES(N), .MAX_PER_LINE(MAXL), .SPRITE_SIZE(SZ)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  typedef struct {
    int x;
    int y;
    int idx;
  } ent_t;

  int   t_x [N];
  int   t_y [N];
  int   t_idx [N];
  bit   t_en [N];
  ent_t m_pend[$];
  ent_t m_act[$];
  ent_t ne;
  int   phase = -1;
  int   m_line = 0;
  int   m_vis = 0;
  int   px;
  bit   found;
  int   e_busy = 0, e_hit = 0, e_x = 0, e_y = 0, e_idx = 0, e_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the active list is a queue replaced whole at the end of a completed scan;
  // the pixel result is the first queue entry covering pix_x, as seen one cycle later.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) t_en[i] = 1'b0;
      m_pend.delete();
      m_act.delete();
      phase = -1;
      m_vis = 0;
      e_hit = 0; e_x = 0; e_y = 0; e_idx = 0; e_ovf = 0;
    end else begin
      px = int'(bus.pix_x);
      found = 1'b0;
      e_hit = 0; e_x = 0; e_y = 0; e_idx = 0;
      foreach (m_act[i]) begin
        if (!found && px >= m_act[i].x && px < m_act[i].x + SZ) begin
          found = 1'b1;
          e_hit = 1; e_x = m_act[i].x; e_y = m_act[i].y; e_idx = m_act[i].idx;
        end
      end
      if (bus.line_start) begin
        m_pend.delete();
        m_vis  = 0;
        m_line = int'(bus.line_y);
        phase  = 0;
      end else if (phase >= 0 && phase < N) begin
        if (t_en[phase] && m_line >= t_y[phase] && m_line < t_y[phase] + SZ) begin
          m_vis++;
          if (m_pend.size() < MAXL) begin
            ne.x = t_x[phase]; ne.y = t_y[phase]; ne.idx = t_idx[phase];
            m_pend.push_back(ne);
          end
        end
        phase++;
      end else if (phase == N) begin
        m_act = m_pend;
        e_ovf = (OVF_EN && m_vis > MAXL) ? 1 : 0;
        phase = -1;
      end
      if (bus.wr_en) begin
        t_x[int'(bus.wr_sel)]   = int'(bus.wr_x);
        t_y[int'(bus.wr_sel)]   = int'(bus.wr_y);
        t_idx[int'(bus.wr_sel)] = int'(bus.wr_index);
        t_en[int'(bus.wr_sel)]  = bus.wr_enable;
      end
    end
    e_busy = (phase != -1) ? 1 : 0;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", bus.busy, e_busy);
      chk("sprite_hit", bus.sprite_hit, e_hit);
      chk("sprite_x", bus.sprite_x, e_x);
      chk("sprite_y", bus.sprite_y, e_y);
      chk("sprite_index", bus.sprite_index, e_idx);
      chk("overflow", bus.overflow, e_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input int sel, input int x, input int y, input int idx, input bit en);
    bus.wr_en     = 1'b1;
    bus.wr_sel    = 3'(sel);
    bus.wr_x      = 11'(x);
    bus.wr_y      = 10'(y);
    bus.wr_index  = 4'(idx);
    bus.wr_enable = en;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic line(input int y);
    bus.line_start = 1'b1;
    bus.line_y     = 11'(y);
    tick();
    bus.line_start = 1'b0;
  endtask

  task automatic scan_done(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      tick();
    end
    chk(nm, n, 9);
  endtask

  task automatic pixq(input int p);
    bus.pix_x = 11'(p);
    tick();
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_index = 0;
    bus.wr_enable = 0; bus.line_start = 0; bus.line_y = 0; bus.pix_x = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hit", bus.sprite_hit, 0);
    chk("rst_x", bus.sprite_x, 0);
    chk("rst_ovf", bus.overflow, 0);

    // single sprite
    wr(0, 100, 50, 3, 1'b1);
    line(60);
    scan_done("busy_len_single");
    pixq(100);
    chk("single_hit", bus.sprite_hit, 1);
    chk("single_x", bus.sprite_x, 100);
    chk("single_y", bus.sprite_y, 50);
    chk("single_idx", bus.sprite_index, 3);
    pixq(131);
    chk("single_edge_hit", bus.sprite_hit, 1);
    pixq(132);
    chk("single_past_hit", bus.sprite_hit, 0);
    chk("single_past_idx", bus.sprite_index, 0);

    // priority between overlapping entries
    do_reset();
    wr(0, 200, 10, 1, 1'b1);
    wr(5, 200, 10, 6, 1'b1);
    line(20);
    scan_done("busy_len_prio");
    pixq(210);
    chk("prio_idx0", bus.sprite_index, 1);
    wr(0, 200, 10, 1, 1'b0);
    line(20);
    scan_done("busy_len_prio2");
    pixq(210);
    chk("prio_idx5", bus.sprite_index, 6);

    // six visible, only four kept
    do_reset();
    for (int i = 0; i < 6; i++) wr(i, 40 * i, 0, i + 1, 1'b1);
    line(5);
    scan_done("busy_len_six");
    pixq(125);
    chk("six_slot3", bus.sprite_index, 4);
    pixq(165);
    chk("six_drop4", bus.sprite_hit, 0);
    pixq(205);
    chk("six_drop5", bus.sprite_hit, 0);
    chk("six_ovf", bus.overflow, OVF_EN);
    for (int i = 2; i < 6; i++) wr(i, 40 * i, 0, i + 1, 1'b0);
    line(5);
    scan_done("busy_len_two");
    chk("two_ovf", bus.overflow, 0);
    pixq(45);
    chk("two_idx", bus.sprite_index, 2);

    // 12-bit compare boundaries
    do_reset();
    wr(3, 2030, 1000, 9, 1'b1);
    line(1031);
    scan_done("busy_len_bound");
    pixq(2047);
    chk("bound_hit", bus.sprite_hit, 1);
    chk("bound_idx", bus.sprite_index, 9);
    pixq(2029);
    chk("bound_left", bus.sprite_hit, 0);
    line(1032);
    scan_done("busy_len_bound2");
    pixq(2047);
    chk("bound_below", bus.sprite_hit, 0);

    // abort and restart mid-scan
    do_reset();
    wr(1, 50, 0, 7, 1'b1);
    wr(2, 50, 200, 2, 1'b1);
    line(5);
    scan_done("busy_len_pre");
    pixq(60);
    chk("abort_pre", bus.sprite_index, 7);
    line(10);
    tick();
    tick();
    line(205);
    chk("abort_keep_hit", bus.sprite_hit, 1);
    chk("abort_keep_idx", bus.sprite_index, 7);
    scan_done("busy_len_restart");
    pixq(60);
    chk("abort_new_idx", bus.sprite_index, 2);

    // reset beats write and line_start mid-scan
    do_reset();
    wr(0, 100, 50, 3, 1'b1);
    line(60);
    scan_done("busy_len_rst");
    pixq(100);
    chk("rst_pre_hit", bus.sprite_hit, 1);
    line(60);
    tick();
    reset = 1'b1;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd1; bus.wr_x = 11'd100; bus.wr_y = 10'd50;
    bus.wr_index = 4'd5; bus.wr_enable = 1'b1;
    bus.line_start = 1'b1; bus.line_y = 11'd60;
    tick();
    reset = 1'b0; bus.wr_en = 1'b0; bus.line_start = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hit", bus.sprite_hit, 0);
    chk("midrst_x", bus.sprite_x, 0);
    chk("midrst_idx", bus.sprite_index, 0);
    chk("midrst_ovf", bus.overflow, 0);
    line(60);
    scan_done("busy_len_post_rst");
    pixq(100);
    chk("midrst_table_clear", bus.sprite_hit, 0);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bus.wr_en     = ($urandom_range(0, 5) == 0);
      bus.wr_sel    = 3'($urandom_range(0, 7));
      bus.wr_x      = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2000, 2047)) : 11'($urandom_range(0, 200));
      bus.wr_y      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 60));
      bus.wr_index  = 4'($urandom_range(0, 15));
      bus.wr_enable = ($urandom_range(0, 3) != 0);
      bus.line_start = ($urandom_range(0, 14) == 0);
      bus.line_y    = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(990, 1060)) : 11'($urandom_range(0, 90));
      bus.pix_x     = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2000, 2047)) : 11'($urandom_range(0, 240));
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.line_start = 1'b0;
    reset = 1'b0;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
